// File: rtl/write_pointer_handler_sync.sv
// Write-domain pointer controller for an asynchronous FIFO: synchronizes the Gray read
// pointer, advances the write pointer and derives registered full/almost-full/level/overflow.
module write_pointer_handler_sync #(
  parameter int ADDR_WIDTH         = 4,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                  write_clock,
  input  logic                  write_reset_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH:0]   read_ptr,
  input  logic                  overflow_clear,
  output logic                  write_accept,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH:0]   write_ptr,
  output logic                  write_full,
  output logic                  write_almost_full,
  output logic [ADDR_WIDTH:0]   write_level,
  output logic                  write_overflow
);

  localparam int AW       = ADDR_WIDTH;
  localparam int AF_LIMIT = (1 << ADDR_WIDTH) - ALMOST_FULL_MARGIN;
  localparam logic [AW:0] AF_THRESH = AF_LIMIT[AW:0];

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW:0] sync_p [SYNC_STAGES];
  logic [AW:0] sync_rptr;
  logic [AW:0] rbin;
  logic [AW:0] bin_p0;
  logic [AW:0] bin_next;
  logic [AW:0] gray_next;
  logic [AW:0] level_next;
  logic        full_next;
  logic        almost_full_next;

  // Read-pointer synchronizer: plain flop chain, nothing between stages
  always_ff @(posedge write_clock or negedge write_reset_n) begin
    if (!write_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_p[i] <= '0;
      end
    end else begin
      sync_p[0] <= read_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p[i] <= sync_p[i-1];
      end
    end
  end

  assign sync_rptr = sync_p[SYNC_STAGES-1];
  assign rbin      = gray2bin(sync_rptr);

  always_comb begin
    write_accept     = write_enable & ~write_full;
    bin_next         = bin_p0 + (AW+1)'(write_accept);
    gray_next        = bin_next ^ (bin_next >> 1);
    full_next        = (gray_next == {~sync_rptr[AW:AW-1], sync_rptr[AW-2:0]});
    // Stale rbin only ever makes this over-report occupancy
    level_next       = bin_next - rbin;
    almost_full_next = (level_next >= AF_THRESH);
  end

  // Pointer and status registers
  always_ff @(posedge write_clock or negedge write_reset_n) begin
    if (!write_reset_n) begin
      bin_p0            <= '0;
      write_ptr         <= '0;
      write_full        <= 1'b0;
      write_almost_full <= 1'b0;
      write_level       <= '0;
      write_overflow    <= 1'b0;
    end else begin
      bin_p0            <= bin_next;
      write_ptr         <= gray_next;
      write_full        <= full_next;
      write_almost_full <= almost_full_next;
      write_level       <= level_next;
      // Set has priority over clear
      write_overflow    <= (write_enable & write_full) | (write_overflow & ~overflow_clear);
    end
  end

  assign write_addr = bin_p0[AW-1:0];

endmodule

// File: doc/write_pointer_handler_sync.md
# write_pointer_handler_sync

Parametrised write-domain pointer controller for the asynchronous FIFO. It contains its own multi-stage read-pointer synchronizer, so the raw Gray-coded read pointer from the read domain can be connected directly. It produces the write address, the Gray write pointer for the read domain, and registered full, almost-full, fill-level and sticky-overflow status. It sits between the write-side client and the dual-port FIFO memory.

## Interface
- ADDR_WIDTH, 4, address bits; depth = 2^ADDR_WIDTH; legal range ≥ 2.
- SYNC_STAGES, 2, flops in the read-pointer synchronizer; legal range ≥ 2.
- ALMOST_FULL_MARGIN, 2, almost-full asserts when free slots ≤ this value; legal range 1 .. 2^ADDR_WIDTH-1.

Ports (clock and reset first):
- write_clock  in  1  write-domain clock; all state updates on its rising edge.
- write_reset_n  in  1  asynchronous, active-low reset; one clock, no other reset.
- write_enable  in  1  write request for the current cycle.
- read_ptr  in  ADDR_WIDTH+1  Gray read pointer, unsynchronized, from the read domain.
- overflow_clear  in  1  clears write_overflow.
- write_accept  out  1  combinational; equals write_enable & ~write_full.
- write_addr  out  ADDR_WIDTH  memory write address; the low bits of the binary pointer register.
- write_ptr  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- write_full  out  1  registered full flag.
- write_almost_full  out  1  registered almost-full flag.
- write_level  out  ADDR_WIDTH+1  registered occupancy as seen from the write domain, 0..2^ADDR_WIDTH.
- write_overflow  out  1  sticky flag: a write was attempted while full.

## Operation
- **Synchronizer.** read_ptr feeds a SYNC_STAGES-deep flop chain. The last stage is sync_rptr. No logic sits between stages.
- **Read pointer conversion.** rbin = gray2bin(sync_rptr), computed as a prefix XOR from the MSB down.
- **Accept.** accept = write_enable & ~write_full. A write presented while full is dropped: pointers are unchanged and no memory write is enabled.
- **Write pointer.** bin_next = bin + accept, modulo 2^(ADDR_WIDTH+1), so it wraps silently. gray_next = bin_next ^ (bin_next >> 1). Both bin and write_ptr register their next values every cycle.
- **Full.** full_next = (gray_next == {~sync_rptr[AW:AW-1], sync_rptr[AW-2:0]}).
- **Level.** level_next = (bin_next - rbin) modulo 2^(ADDR_WIDTH+1), evaluated at full width.
  - The read pointer is stale, so the level is pessimistic: it may over-report occupancy but never under-reports it.
- **Almost full.** almost_full_next = (level_next ≥ 2^ADDR_WIDTH - ALMOST_FULL_MARGIN).
- **Overflow.** write_overflow sets when write_enable & write_full, and clears when overflow_clear is high.
  - If set and clear occur in the same cycle, set wins.
- **Consistency invariant.** Whenever write_full = 1, write_level = 2^ADDR_WIDTH and write_almost_full = 1.
- **Reset.** While write_reset_n is low, all of the following are 0 immediately (asynchronously), including reset asserted mid-operation:
  - synchronizer flops, bin, write_ptr, write_addr;
  - write_full, write_almost_full, write_level, write_overflow.
- **Reset release.** State updates resume on the first rising edge after release.

## Timing
- **Write.** An accepted write at edge k updates write_addr, write_ptr and write_level at edge k.
  - The write that fills the last slot asserts write_full at that same edge k.
  - write_accept drops in the cycle after it.
- **Memory address.** Memory writes use the write_addr value present before edge k.
- **Read-side change.** A change on read_ptr captured at edge j reaches sync_rptr at edge j+SYNC_STAGES-1.
  - write_level, write_full and write_almost_full reflect it at edge j+SYNC_STAGES.
- **Simultaneous events.** A write accept and a read-pointer change in the same cycle are both reflected in level_next; the net change can be 0.
- **Overflow.** write_overflow rises one edge after the offending request cycle.
- **Wrap-around.** After 2^(ADDR_WIDTH+1) accepted writes, bin and write_ptr return to 0. Flags stay correct across the wrap because level arithmetic is modulo 2^(ADDR_WIDTH+1).

## Test plan
All scenarios use ADDR_WIDTH=4, SYNC_STAGES=2, ALMOST_FULL_MARGIN=2.

- **Reset and fill.** Reset, hold read_ptr=0, then 16 consecutive writes.
  - write_almost_full rises at the edge where write_level reaches 14.
  - write_full rises with the 16th write; write_level=16, write_ptr=5'b11000, write_addr=0.
  - write_accept=0 afterwards.
- **Overflow.** While full, write_enable=1 for 3 cycles.
  - write_ptr stays 5'b11000; write_overflow=1 from the next edge.
  - overflow_clear and write_enable high in the same cycle: write_overflow stays 1.
  - overflow_clear alone: write_overflow goes to 0.
- **Synchronizer latency.** From full, set read_ptr to gray(1)=5'b00001 at edge j.
  - write_full=0 and write_level=15 exactly at edge j+2; both unchanged at edge j+1.
- **Wrap-around.** Stream 40 writes with read_ptr tracking 4 behind (Gray of bin-4, updated each cycle).
  - write_full never asserts; write_level settles at 6.
  - write_ptr wraps from Gray(31)=5'b10000 to 5'b00000 with no glitch in the flags.
- **Simultaneous write and read advance.** At level 15, one write plus a read_ptr advance of 1 reaching sync_rptr in the same cycle.
  - write_level stays 15, write_full stays 0.
- **Reset mid-operation.** Pulse write_reset_n low between clock edges at level 10.
  - All outputs read 0 before the next edge.
  - The first accepted write after release sets write_addr=1, write_ptr=5'b00001, write_level=1.
